// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a 16-byte register window in front of a
// byte FIFO that a serial engine drains onto the tx pin.
module uart_tx_mmio #(
  parameter logic [31:0] BASE        = 32'hF000_0000,
  parameter int          FIFO_AW     = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] address,
  input  logic [31:0] memory_in,
  input  logic [3:0]  write_enable,
  output logic [31:0] memory_out,
  output logic        read_capable,
  output logic        write_capable,
  output logic        tx
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = DEPTH[FIFO_AW:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  logic             hit_s;
  logic [1:0]       offset_s;
  logic             push_req_s;
  logic             push_ok_s;
  logic             pop_s;
  logic             ovf_clr_s;
  logic             empty_s;
  logic             full_s;
  logic             busy_s;
  logic [7:0]       count8_s;
  logic [15:0]      period_m1_s;
  logic             unused_s;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               ovf_q;
  logic [15:0]        div_q;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  // address [29:2] is byte address [31:4]
  assign hit_s         = (address[29:2] == BASE[31:4]);
  assign offset_s      = address[1:0];
  assign read_capable  = hit_s;
  assign write_capable = hit_s;

  assign empty_s     = (count_q == {(FIFO_AW+1){1'b0}});
  assign full_s      = (count_q == DEPTH_C);
  assign busy_s      = (state_q != S_IDLE);
  assign count8_s    = 8'(count_q);
  assign pop_s       = (state_q == S_IDLE) && !empty_s;
  assign push_req_s  = hit_s && (offset_s == 2'd0) && write_enable[0];
  assign push_ok_s   = push_req_s && (!full_s || pop_s);
  assign ovf_clr_s   = hit_s && (offset_s == 2'd1) && write_enable[0] && memory_in[3];
  assign period_m1_s = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);
  assign unused_s    = ^{memory_in[31:16], write_enable[3:2]};
  assign tx          = tx_q;

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {FIFO_AW{1'b0}};
      rd_ptr_q <= {FIFO_AW{1'b0}};
      count_q  <= {(FIFO_AW+1){1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop_s)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push_req_s && !push_ok_s) ovf_q <= 1'b1;
      else if (ovf_clr_s)           ovf_q <= 1'b0;
    end
  end

  // FIFO storage; contents are meaningless outside the occupied range
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= memory_in[7:0];
  end

  // bit-period divider, byte-lane writable
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DEFAULT_DIV;
    end else if (hit_s && (offset_s == 2'd2)) begin
      if (write_enable[0]) div_q[7:0]  <= memory_in[7:0];
      if (write_enable[1]) div_q[15:8] <= memory_in[15:8];
    end
  end

  // serial engine state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // serial engine next state; cnt counts down the remaining cycles of a bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = period_m1_s;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = period_m1_s;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = period_m1_s;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // register read mux; reads have no side effects
  always_comb begin
    memory_out = 32'd0;
    if (hit_s) begin
      case (offset_s)
        2'd1:    memory_out = {16'd0, count8_s, 4'd0, ovf_q, busy_s, empty_s, full_s};
        2'd2:    memory_out = {16'd0, div_q};
        default: memory_out = 32'd0;
      endcase
    end else begin
      memory_out = 32'd0;
    end
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter attached downstream of the cpu data/instruction bus, next to the RAM, behind the system address decode. The cpu stores bytes into a TX FIFO. A serial engine drains the FIFO onto the tx pin as 8N1 frames. The block drives the bus read data and the read_capable/write_capable qualifiers for its own address window.

Parameters:
BASE, 32'hF000_0000, byte base address of 16-byte window; BASE[3:0] must be 0
FIFO_AW, 4, log2 of FIFO depth (depth 16); FIFO_AW <= 7
DEFAULT_DIV, 16'd868, reset value of bit-period divider in clk cycles

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
address  input  30  word address from cpu (byte address bits 31:2)
memory_in  input  32  write data from cpu, already lane-shifted
write_enable  input  4  byte-lane write strobes from cpu
memory_out  output  32  read data to cpu, combinational
read_capable  output  1  address hits window, combinational
write_capable  output  1  address hits window, combinational
tx  output  1  serial output, idle high

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. At reset: tx=1, FIFO empty, overflow=0, div=DEFAULT_DIV, FSM=IDLE.
- Reset applies on the next edge even mid-frame. tx returns to 1 and FIFO contents are discarded.
- hit = (address[31:4] == BASE[31:4]). Offset = address[3:2].
- read_capable = write_capable = hit. When not hit: memory_out=0 and writes are ignored.
- Offset 0, TXDATA:
  - Edge with hit and write_enable[0] pushes memory_in[7:0].
  - Other lanes are ignored. A read returns 0.
- Offset 1, STATUS, read:
  - bit0 full, bit1 empty, bit2 busy (FSM!=IDLE), bit3 overflow.
  - bits[15:8] FIFO count, zero-extended. All other bits 0.
  - Write with write_enable[0] and memory_in[3]=1 clears overflow (W1C). Other bits are ignored.
- Offset 2, DIV:
  - Read returns {16'd0, div}.
  - write_enable[0] updates div[7:0]; write_enable[1] updates div[15:8]. Lanes 2-3 are ignored.
- Offset 3: reserved; reads 0, writes ignored.
- memory_out is purely combinational from address and current state; no read side effects.
- FIFO:
  - Push is accepted if count < depth, or if a pop occurs on the same edge.
  - A rejected push drops the byte and sets overflow.
  - If an overflow set and a W1C clear occur on the same edge, the set wins.
  - count is FIFO_AW+1 bits; pointers wrap modulo depth.
- Bit period P = max(div,1) clk cycles. The bit counter reloads from div at the start of each bit, so a div change takes effect at the next bit boundary.
- FSM:
  - IDLE: tx=1. If FIFO is non-empty: pop the head into the shift register, go to START.
  - START: tx=0 for P cycles, then go to DATA.
  - DATA: 8 bits, LSB first, tx=shift[0] for P cycles each. Shift right after each bit; after the 8th bit go to STOP.
  - STOP: tx=1 for P cycles, then go to IDLE.
- Latency:
  - A push on edge E0 into an empty FIFO with FSM idle gives a pop on edge E1, and tx=0 from E1 for P cycles.
  - The frame lasts 10*P cycles.
  - Back-to-back frames are separated by exactly 1 IDLE cycle (tx=1).
- busy is 0 only in IDLE. empty and busy both 0 means the transmitter is fully drained.
- Simultaneous push and pop: count is unchanged and both operations take effect.

Test Plan:
- Reset: assert rst 2 cycles -> tx=1; STATUS read = 32'h0000_0002; DIV read = 868; read_capable=1 at BASE, 0 at BASE+16.
- Single frame: write DIV=4, write TXDATA 0x55 on edge E0 -> tx=0 over E1..E1+4, then 1,0,1,0,1,0,1,0 per 4 cycles, stop=1. busy=0 at E1+40. empty=1 throughout after E1.
- Back-to-back: DIV=2, push 0xA5 then 0x3C on consecutive cycles -> two frames of 20 cycles separated by 1 idle cycle. Bit patterns LSB first are correct.
- Overflow: DIV=1000, push 18 bytes in 18 cycles:
  - First byte popped to the engine; 16 bytes stored; 18th byte dropped.
  - STATUS = full=1, overflow=1, count=16.
  - Write STATUS 0x8 -> overflow=0, full still 1.
- Lane/offset handling:
  - TXDATA write with write_enable=4'b0010 -> no push.
  - DIV write with 4'b0001 of 0x12 over div=0x0364 -> DIV reads 0x0312.
  - Offset 3 reads 0.
  - DIV=0 -> bit period 1 cycle.
- Reset mid-frame: DIV=8, start a frame, assert rst during DATA with 3 bytes queued -> tx=1 after the edge; STATUS=0x2; no further frames.
